// File: rtl/ber_pkg.sv
// ber_pkg: shared types and defaults for the bit-error-rate monitor.
//   state_e   : monitor state (skip warm-up bits, count, hold at saturation)
//   DEF_*     : default parameter values for ber_monitor
package ber_pkg;

   localparam int STATE_W   = 2;
   localparam int DEF_DEPTH = 128;
   localparam int DEF_SKIP  = 16;
   localparam int DEF_CNT_W = 32;

   typedef enum logic [STATE_W-1:0] {
      S_SKIP  = 2'd0,
      S_COUNT = 2'd1,
      S_HOLD  = 2'd2
   } state_e;

endpackage

// File: rtl/bit_fifo.sv
// bit_fifo: single-bit alignment FIFO holding transmitted bits until the
// decoded copy arrives.
//   clk, rst     : clock, async active-low reset
//   clr_i        : synchronous flush (overrides push/pop)
//   push_i/din_i : write request and data; refused when full unless popping
//   pop_i        : read request; ignored when empty
//   dout_o       : current head bit
//   full_o/empty_o
module bit_fifo #(
   parameter int DEPTH = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic clr_i,
   input  logic push_i,
   input  logic pop_i,
   input  logic din_i,
   output logic dout_o,
   output logic full_o,
   output logic empty_o
);

   localparam int AW = $clog2(DEPTH);

   // One extra pointer bit separates full (MSBs differ) from empty.
   logic [AW:0] wr_ptr_q, rd_ptr_q;
   logic        mem_q [DEPTH];
   logic        do_push, do_pop;

   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign do_pop  = pop_i & ~empty_o;
   // A pop frees the head slot in the same cycle, so a full FIFO still accepts.
   assign do_push = push_i & (~full_o | do_pop);
   assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else if (clr_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !clr_i) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
   end

endmodule

// File: rtl/ber_monitor.sv
// ber_monitor: compares decoded bits against the transmitted stream and
// counts bit errors after a warm-up skip window.
//   clk, rst              : clock, async active-low reset
//   clear_i               : sync clear of FIFO, counters, flags and state
//   tx_bit_i/tx_valid_i   : source bits, queued for alignment
//   rx_bit_i/rx_valid_i   : decoded bits, compared against the queue head
//   state_o               : S_SKIP / S_COUNT / S_HOLD
//   bit_count_o/err_count_o : compared bits / mismatches
//   ovf_o/unf_o           : sticky FIFO overflow / underflow
//   err_pulse_o           : one-cycle pulse per counted mismatch
//
// state   | meaning
// S_SKIP  | discarding decoder warm-up pairs
// S_COUNT | comparing pairs and counting errors
// S_HOLD  | bit counter saturated, counters frozen
module ber_monitor
   import ber_pkg::*;
#(
   parameter int DEPTH = DEF_DEPTH,
   parameter int SKIP  = DEF_SKIP,
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               clear_i,
   input  logic               tx_bit_i,
   input  logic               tx_valid_i,
   input  logic               rx_bit_i,
   input  logic               rx_valid_i,
   output logic [STATE_W-1:0] state_o,
   output logic [CNT_W-1:0]   bit_count_o,
   output logic [CNT_W-1:0]   err_count_o,
   output logic               ovf_o,
   output logic               unf_o,
   output logic               err_pulse_o
);

   localparam int             SKW       = (SKIP > 0) ? $clog2(SKIP + 1) : 1;
   localparam logic [SKW-1:0] SKIP_LAST = (SKIP > 0) ? SKW'(SKIP - 1) : '0;
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [CNT_W-1:0] CNT_LAST = {{(CNT_W-1){1'b1}}, 1'b0};
   localparam state_e         INIT_ST   = (SKIP == 0) ? S_COUNT : S_SKIP;

   state_e           state_q, state_d;
   logic [SKW-1:0]   skip_q, skip_d;
   logic [CNT_W-1:0] bit_q, bit_d, err_q, err_d;
   logic             ovf_q, ovf_d, unf_q, unf_d, pulse_q, pulse_d;
   logic             head_bit, fifo_full, fifo_empty, pop_ok, mismatch;

   bit_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .clr_i   (clear_i),
      .push_i  (tx_valid_i),
      .pop_i   (rx_valid_i),
      .din_i   (tx_bit_i),
      .dout_o  (head_bit),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   assign pop_ok   = rx_valid_i & ~fifo_empty;
   assign mismatch = head_bit ^ rx_bit_i;

   always_comb begin
      state_d = state_q;
      skip_d  = skip_q;
      bit_d   = bit_q;
      err_d   = err_q;
      pulse_d = 1'b0;
      ovf_d   = ovf_q | (tx_valid_i & fifo_full & ~pop_ok);
      unf_d   = unf_q | (rx_valid_i & fifo_empty);
      if (clear_i) begin
         state_d = INIT_ST;
         skip_d  = '0;
         bit_d   = '0;
         err_d   = '0;
         ovf_d   = 1'b0;
         unf_d   = 1'b0;
      end else if (pop_ok) begin
         unique case (state_q)
            S_SKIP: begin
               skip_d = skip_q + SKW'(1);
               // Leave right after the last skipped pop so the next pair counts.
               if (skip_q == SKIP_LAST) state_d = S_COUNT;
            end
            S_COUNT: begin
               bit_d = bit_q + CNT_W'(1);
               if (mismatch && (err_q != CNT_MAX)) begin
                  err_d   = err_q + CNT_W'(1);
                  pulse_d = 1'b1;
               end
               if (bit_q == CNT_LAST) state_d = S_HOLD;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= INIT_ST;
         skip_q  <= '0;
         bit_q   <= '0;
         err_q   <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
         pulse_q <= 1'b0;
      end else begin
         state_q <= state_d;
         skip_q  <= skip_d;
         bit_q   <= bit_d;
         err_q   <= err_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
         pulse_q <= pulse_d;
      end
   end

   assign state_o     = state_q;
   assign bit_count_o = bit_q;
   assign err_count_o = err_q;
   assign ovf_o       = ovf_q;
   assign unf_o       = unf_q;
   assign err_pulse_o = pulse_q;

endmodule
